// File: rtl/rf_wb_sched_if.sv
// Write-back request bundle between the producers and the scheduler.
// Requester k owns slice k of each packed field.
interface rf_wb_sched_if #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned DW   = 32
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*5-1:0]  req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;

  modport master (
    output req_valid,
    output req_addr,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_data,
    output req_ready
  );
endinterface

// File: rtl/rf_wb_sched.sv
// Write-back scheduler for the RV32I register file: arbitrates the single write port
// among producers and keeps a busy scoreboard for in-flight long-latency destinations.
module rf_wb_sched #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned DW   = 32
) (
  input  logic          i_clk,
  input  logic          i_reset,
  rf_wb_sched_if.slave  req,
  output logic          o_rd_wren,
  output logic [4:0]    o_rd_addr,
  output logic [DW-1:0] o_rd_data,
  input  logic          i_alloc_valid,
  input  logic [4:0]    i_alloc_addr,
  output logic          o_alloc_ready,
  input  logic [4:0]    i_rs1_addr,
  input  logic [4:0]    i_rs2_addr,
  output logic          o_rs1_busy,
  output logic          o_rs2_busy,
  output logic [31:0]   o_busy_vec
);
  localparam int unsigned PW = $clog2(NREQ);

  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0] grant;
  logic [PW-1:0]   grant_idx;
  logic            grant_any;
  logic [4:0]      sel_addr;
  logic [DW-1:0]   sel_data;
  logic            wren_q;
  logic [4:0]      waddr_q;
  logic [DW-1:0]   wdata_q;
  logic [31:0]     busy_q, busy_d;
  logic            alloc_fire;

  // req0 wins outright; otherwise scan 1..NREQ-1 starting at rr_ptr.
  always_comb begin : arb
    int unsigned cand;
    logic [PW-1:0] cand_idx;
    cand      = 0;
    cand_idx  = '0;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    if (req.req_valid[0]) begin
      grant[0]  = 1'b1;
      grant_any = 1'b1;
    end else begin
      for (int unsigned off = 0; off < NREQ - 1; off++) begin
        cand     = (32'(rr_ptr_q) - 32'd1 + off) % (NREQ - 1) + 32'd1;
        cand_idx = cand[PW-1:0];
        if (!grant_any && req.req_valid[cand_idx]) begin
          grant[cand_idx] = 1'b1;
          grant_idx       = cand_idx;
          grant_any       = 1'b1;
        end
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_any && !req.req_valid[0]) begin
      rr_ptr_d = (grant_idx == PW'(NREQ - 1)) ? PW'(1) : grant_idx + PW'(1);
    end
  end

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (grant[k[PW-1:0]]) begin
        sel_addr = req.req_addr[5*k +: 5];
        sel_data = req.req_data[DW*k +: DW];
      end
    end
  end

  assign req.req_ready = grant;

  assign alloc_fire    = i_alloc_valid && !busy_q[i_alloc_addr];
  assign o_alloc_ready = !busy_q[i_alloc_addr];

  // Clear follows the write actually presented to the regfile this cycle.
  always_comb begin
    busy_d = busy_q;
    if (wren_q) busy_d[waddr_q] = 1'b0;
    if (alloc_fire) busy_d[i_alloc_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      wren_q   <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      busy_q   <= '0;
      rr_ptr_q <= PW'(1);
    end else begin
      wren_q <= grant_any && (sel_addr != 5'd0);
      if (grant_any) begin
        waddr_q <= sel_addr;
        wdata_q <= sel_data;
      end
      busy_q   <= busy_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign o_rd_wren  = wren_q;
  assign o_rd_addr  = waddr_q;
  assign o_rd_data  = wdata_q;
  assign o_rs1_busy = busy_q[i_rs1_addr];
  assign o_rs2_busy = busy_q[i_rs2_addr];
  assign o_busy_vec = busy_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      assert ($onehot0(grant));
      assert (!busy_q[0]);
    end
  end
endmodule

// File: tb/tb_rf_wb_sched.sv
// Randomized self-checking bench for rf_wb_sched against a behavioural model
// of the arbitration, registered write port and busy scoreboard.
module tb_rf_wb_sched;
  localparam int unsigned NREQ = 3;
  localparam int unsigned DW   = 32;

  logic          i_clk = 1'b0;
  logic          i_reset;
  logic          o_rd_wren;
  logic [4:0]    o_rd_addr;
  logic [DW-1:0] o_rd_data;
  logic          i_alloc_valid;
  logic [4:0]    i_alloc_addr;
  logic          o_alloc_ready;
  logic [4:0]    i_rs1_addr, i_rs2_addr;
  logic          o_rs1_busy, o_rs2_busy;
  logic [31:0]   o_busy_vec;

  rf_wb_sched_if #(.NREQ(NREQ), .DW(DW)) ifc ();

  rf_wb_sched #(.NREQ(NREQ), .DW(DW)) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .req           (ifc),
    .o_rd_wren     (o_rd_wren),
    .o_rd_addr     (o_rd_addr),
    .o_rd_data     (o_rd_data),
    .i_alloc_valid (i_alloc_valid),
    .i_alloc_addr  (i_alloc_addr),
    .o_alloc_ready (o_alloc_ready),
    .i_rs1_addr    (i_rs1_addr),
    .i_rs2_addr    (i_rs2_addr),
    .o_rs1_busy    (o_rs1_busy),
    .o_rs2_busy    (o_rs2_busy),
    .o_busy_vec    (o_busy_vec)
  );

  always #5 i_clk = ~i_clk;

  int n_vec = 0;
  int n_err = 0;

  // Producer-side request state.
  logic          p_valid [NREQ];
  logic [4:0]    p_addr  [NREQ];
  logic [DW-1:0] p_data  [NREQ];

  // Reference model state.
  logic [31:0]   m_busy;
  int            m_rr;
  logic          m_wren;
  logic [4:0]    m_addr;
  logic [DW-1:0] m_data;
  int            last_grant;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive();
    for (int k = 0; k < NREQ; k++) begin
      ifc.req_valid[k]         = p_valid[k];
      ifc.req_addr[5*k +: 5]   = p_addr[k];
      ifc.req_data[DW*k +: DW] = p_data[k];
    end
  endtask

  task automatic put(input int k, input logic [4:0] a, input logic [DW-1:0] d);
    p_valid[k] = 1'b1;
    p_addr[k]  = a;
    p_data[k]  = d;
    drive();
  endtask

  task automatic clr(input int k);
    p_valid[k] = 1'b0;
    drive();
  endtask

  // Priority to req0, then first valid in the rotation m_rr, m_rr+1, ... over 1..NREQ-1.
  function automatic int model_pick();
    if (p_valid[0]) return 0;
    for (int n = 0; n < NREQ - 1; n++) begin
      int k = m_rr + n;
      if (k > NREQ - 1) k -= NREQ - 1;
      if (p_valid[k]) return k;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = '0;
    m_rr   = 1;
    m_wren = 1'b0;
    m_addr = '0;
    m_data = '0;
  endtask

  // Check every output just after inputs settle, then advance model and DUT one edge.
  task automatic cycle();
    int g;
    logic [NREQ-1:0] exp_rdy;
    logic [31:0] nb;
    #1;
    g = model_pick();
    exp_rdy = (g >= 0) ? NREQ'(1 << g) : '0;
    check_eq("ready", 64'(ifc.req_ready), 64'(exp_rdy));
    check_eq("wren", 64'(o_rd_wren), 64'(m_wren));
    check_eq("waddr", 64'(o_rd_addr), 64'(m_addr));
    check_eq("wdata", 64'(o_rd_data), 64'(m_data));
    check_eq("busy_vec", 64'(o_busy_vec), 64'(m_busy));
    check_eq("rs1_busy", 64'(o_rs1_busy), 64'(m_busy[i_rs1_addr]));
    check_eq("rs2_busy", 64'(o_rs2_busy), 64'(m_busy[i_rs2_addr]));
    check_eq("alloc_rdy", 64'(o_alloc_ready), 64'(!m_busy[i_alloc_addr]));
    @(posedge i_clk);
    if (!i_reset) begin
      model_reset();
      last_grant = -1;
    end else begin
      nb = m_busy;
      if (m_wren) nb[m_addr] = 1'b0;
      if (i_alloc_valid && !m_busy[i_alloc_addr] && i_alloc_addr != 0) nb[i_alloc_addr] = 1'b1;
      m_busy = nb;
      if (g >= 0) begin
        m_wren = (p_addr[g] != 0);
        m_addr = p_addr[g];
        m_data = p_data[g];
        if (g > 0) m_rr = (g == NREQ - 1) ? 1 : g + 1;
      end else begin
        m_wren = 1'b0;
      end
      last_grant = g;
    end
    @(negedge i_clk);
  endtask

  initial begin
    for (int k = 0; k < NREQ; k++) begin
      p_valid[k] = 1'b0;
      p_addr[k]  = '0;
      p_data[k]  = '0;
    end
    i_reset = 1'b0;
    i_alloc_valid = 1'b0;
    i_alloc_addr = '0;
    i_rs1_addr = '0;
    i_rs2_addr = '0;
    last_grant = -1;
    for (int k = 0; k < NREQ; k++) put(k, 5'(k + 1), 32'(k));

    // Reset held two cycles with every requester valid.
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    model_reset();
    #1;
    check_eq("rst_wren", 64'(o_rd_wren), 64'd0);
    check_eq("rst_busy", 64'(o_busy_vec), 64'd0);
    i_reset = 1'b1;
    clr(0);
    #1;
    check_eq("rst_rr", 64'(ifc.req_ready), 64'b010);
    cycle();
    clr(1);
    clr(2);
    cycle();

    // req0 beats req1 in the same cycle.
    put(0, 5'd5, 32'h11);
    put(1, 5'd6, 32'h22);
    #1;
    check_eq("t2_rdy0", 64'(ifc.req_ready), 64'b001);
    cycle();
    clr(0);
    #1;
    check_eq("t2_rdy1", 64'(ifc.req_ready), 64'b010);
    check_eq("t2_w5", {o_rd_wren, 27'd0, o_rd_addr, o_rd_data}, {1'b1, 27'd0, 5'd5, 32'h11});
    cycle();
    clr(1);
    #1;
    check_eq("t2_w6", {o_rd_wren, 27'd0, o_rd_addr, o_rd_data}, {1'b1, 27'd0, 5'd6, 32'h22});
    cycle();

    // req1/req2 continuously valid: rotation alternates starting from req2.
    put(1, 5'd10, 32'h100);
    put(2, 5'd11, 32'h200);
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq("t3_rdy", 64'(ifc.req_ready), (i % 2 == 0) ? 64'b100 : 64'b010);
      if (i > 0) check_eq("t3_waddr", 64'(o_rd_addr), (i % 2 == 1) ? 64'd11 : 64'd10);
      cycle();
      if (last_grant > 0) put(last_grant, p_addr[last_grant], p_data[last_grant] + 1);
    end
    clr(1);
    clr(2);
    cycle();

    // Scoreboard set, WAW block, and clear after the write lands.
    i_alloc_valid = 1'b1;
    i_alloc_addr  = 5'd7;
    cycle();
    i_alloc_valid = 1'b0;
    i_rs1_addr    = 5'd7;
    #1;
    check_eq("t4_busy7", 64'(o_busy_vec[7]), 64'd1);
    check_eq("t4_rs1", 64'(o_rs1_busy), 64'd1);
    i_alloc_valid = 1'b1;
    #1;
    check_eq("t4_waw", 64'(o_alloc_ready), 64'd0);
    cycle();
    i_alloc_valid = 1'b0;
    put(2, 5'd7, 32'hDEAD);
    cycle();
    clr(2);
    #1;
    check_eq("t4_wr7", {o_rd_wren, 27'd0, o_rd_addr, o_rd_data}, {1'b1, 27'd0, 5'd7, 32'hDEAD});
    check_eq("t4_still", 64'(o_busy_vec[7]), 64'd1);
    cycle();
    #1;
    check_eq("t4_clear", 64'(o_busy_vec[7]), 64'd0);
    cycle();

    // x0: both alloc and write accepted, neither has an effect.
    i_alloc_valid = 1'b1;
    i_alloc_addr  = 5'd0;
    put(1, 5'd0, 32'hFFFF);
    #1;
    check_eq("t5_alloc", 64'(o_alloc_ready), 64'd1);
    check_eq("t5_rdy", 64'(ifc.req_ready), 64'b010);
    cycle();
    i_alloc_valid = 1'b0;
    clr(1);
    #1;
    check_eq("t5_wren", 64'(o_rd_wren), 64'd0);
    check_eq("t5_busy", 64'(o_busy_vec), 64'd0);
    cycle();

    // Reset lands on the edge of a req1 transfer with x9 busy.
    i_alloc_valid = 1'b1;
    i_alloc_addr  = 5'd9;
    cycle();
    i_alloc_valid = 1'b0;
    #1;
    check_eq("t6_busy9", 64'(o_busy_vec[9]), 64'd1);
    put(1, 5'd9, 32'h5);
    i_reset = 1'b0;
    cycle();
    i_reset = 1'b1;
    clr(1);
    #1;
    check_eq("t6_wren", 64'(o_rd_wren), 64'd0);
    check_eq("t6_busy", 64'(o_busy_vec), 64'd0);
    cycle();

    // Random traffic: producers hold until granted; small address pool forces hazards.
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < NREQ; k++) begin
        if (!p_valid[k] && ($urandom % ((k == 0) ? 6 : 3) == 0)) begin
          p_valid[k] = 1'b1;
          p_addr[k]  = 5'($urandom_range(0, 15));
          p_data[k]  = $urandom;
        end
      end
      drive();
      i_alloc_valid = ($urandom % 2) == 1;
      i_alloc_addr  = 5'($urandom_range(0, 15));
      i_rs1_addr    = 5'($urandom % 32);
      i_rs2_addr    = 5'($urandom % 32);
      cycle();
      if (last_grant >= 0) p_valid[last_grant] = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
